led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N_LED, default 4: number of LED outputs, range 1..16.
REQ-002 Parameter CNT_W, default 32: free-running counter width.
REQ-003 Parameter TAP_TOP, default 26: counter bit driving led[0] in DIV mode; TAP_TOP < CNT_W.
REQ-004 Parameter TAP_STEP, default 2: bit spacing between adjacent LED taps; TAP_TOP-(N_LED-1)*TAP_STEP >= 0.
REQ-005 Parameter TICK_BIT, default 20: tick period = 2^(TICK_BIT+1) enabled cycles; TICK_BIT < CNT_W.
REQ-006 Parameter PWM_W, default 8: duty/compare width; PWM_W <= CNT_W.
REQ-007 clk  in  1  single clock.
REQ-008 rst  in  1  reset is synchronous and active-high.
REQ-009 en  in  1  count enable.
REQ-010 mode  in  2  pattern select: 0 DIV, 1 CHASE, 2 BREATHE, 3 OFF.
REQ-011 led  out  N_LED  registered LED drive.
REQ-012 tick  out  1  registered single-cycle pulse at the pattern step rate.

Function
REQ-013 cnt SHALL increment by 1 each cycle en=1, hold when en=0, and wrap 2^CNT_W-1 -> 0.
REQ-014 tick SHALL be 1 for exactly the cycle after an enabled cycle in which cnt[TICK_BIT:0] is all ones; 0 otherwise.
REQ-015 mode_q SHALL register mode each cycle; a mode change is detected when mode != mode_q.
REQ-016 DIV: led[i] SHALL equal cnt[TAP_TOP-i*TAP_STEP] one cycle after cnt update (led[0] slowest).
REQ-017 CHASE: one-hot register SHALL rotate left by one on each tick, wrapping bit N_LED-1 -> bit 0; led = chase register.
REQ-018 BREATHE: duty (PWM_W bits) SHALL step by 1 per tick in direction dir; at duty=2^PWM_W-1 with dir=up SHALL reverse to down without overflow; at duty=0 with dir=down SHALL reverse to up without underflow.
REQ-019 BREATHE: all led bits SHALL equal (cnt[PWM_W-1:0] < duty), registered; duty=0 gives all LEDs 0.
REQ-020 OFF: led SHALL be all 0; cnt and tick keep running.
REQ-021 On mode change, chase SHALL reload to one-hot bit 0, duty to 0 and dir to up in the same cycle; a coincident tick is discarded (mode change wins).
REQ-022 en=0: cnt, chase, duty, dir and led SHALL hold; tick SHALL be 0.
REQ-023 N_LED=1: CHASE SHALL hold led[0]=1.

Reset
REQ-024 With rst=1 at a clk edge: cnt=0, led=0, tick=0, chase=one-hot bit 0, duty=0, dir=up, mode_q=0.
REQ-025 rst SHALL override en and mode; reset mid-pattern SHALL abandon all state; first output update is the cycle after rst deasserts.

Structure
REQ-026 Package led_pkg SHALL hold enum typedef led_mode_e (DIV, CHASE, BREATHE, OFF) and default parameter constants.
REQ-027 Prescaler (cnt + tick generation) SHALL be sub-module led_tick_gen; pattern logic stays in led_pattern_gen.
REQ-028 Parameter constraints SHALL be checked at elaboration.

Verification (CNT_W=8, TICK_BIT=1, TAP_TOP=7, TAP_STEP=2, N_LED=4, PWM_W=2)
REQ-029 Reset, mode=DIV, en=1 for 256 cycles -> led[3] toggles every 2 cycles, led[0] every 128; tick every 4 cycles; cnt wraps 255->0.
REQ-030 mode=CHASE, en=1 -> led 0001,0010,0100,1000,0001 on successive ticks (4 cycles apart).
REQ-031 mode=BREATHE -> duty sequence 0,1,2,3,2,1,0,1 per tick; at duty=2 led high 2 of every 4 cycles.
REQ-032 en=0 for 10 cycles mid-CHASE -> led frozen, tick=0; resumes at same position after en=1.
REQ-033 Switch CHASE->BREATHE on tick cycle -> tick ignored, duty=0, led=0; then back to CHASE -> led=0001.
REQ-034 rst pulse at led=0100 in CHASE -> next cycle led=0, tick=0; first tick after release shows 0010 from restarted chase.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and default parameters for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    DIV     = 2'd0,
    CHASE   = 2'd1,
    BREATHE = 2'd2,
    OFF     = 2'd3
  } led_mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } led_dir_e;

  localparam int unsigned DefNLed    = 4;
  localparam int unsigned DefCntW    = 32;
  localparam int unsigned DefTapTop  = 26;
  localparam int unsigned DefTapStep = 2;
  localparam int unsigned DefTickBit = 20;
  localparam int unsigned DefPwmW    = 8;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/drive bundle between a pattern generator and whatever steers it.
interface led_pattern_gen_if
  import led_pkg::*;
#(
  parameter int unsigned N_LED = DefNLed
) ();

  logic             en;
  led_mode_e        mode;
  logic [N_LED-1:0] led;
  logic             tick;

  modport master (
    output en,
    output mode,
    input  led,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    output led,
    output tick
  );

endinterface

// File: rtl/led_tick_gen.sv
// Free-running enabled counter plus a registered one-cycle tick each time the
// low TICK_BIT+1 counter bits roll over.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned TICK_BIT = DefTickBit
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  if (TICK_BIT >= CNT_W) begin : g_bad_tick_bit
    $error("led_tick_gen: TICK_BIT must be below CNT_W");
  end

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      if (en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      tick_q <= en && (&cnt_q[TICK_BIT:0]);
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: divided-clock taps, one-hot chase, triangle-PWM breathe
// or off, all stepped by the tick from led_tick_gen.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LED    = DefNLed,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned TAP_TOP  = DefTapTop,
  parameter int unsigned TAP_STEP = DefTapStep,
  parameter int unsigned TICK_BIT = DefTickBit,
  parameter int unsigned PWM_W    = DefPwmW
) (
  input logic               clk,
  input logic               rst,
  led_pattern_gen_if.slave  bus
);

  if (N_LED < 1 || N_LED > 16) begin : g_bad_n_led
    $error("led_pattern_gen: N_LED must be 1..16");
  end
  if (TAP_TOP >= CNT_W) begin : g_bad_tap_top
    $error("led_pattern_gen: TAP_TOP must be below CNT_W");
  end
  if (TAP_TOP < (N_LED - 1) * TAP_STEP) begin : g_bad_tap_step
    $error("led_pattern_gen: lowest LED tap falls below counter bit 0");
  end
  if (PWM_W < 1 || PWM_W > CNT_W) begin : g_bad_pwm_w
    $error("led_pattern_gen: PWM_W must be 1..CNT_W");
  end

  localparam logic [N_LED-1:0] ChaseInit = N_LED'(1);
  localparam logic [PWM_W-1:0] DutyMax   = '1;

  logic [CNT_W-1:0] cnt;
  logic             tick;

  led_tick_gen #(
    .CNT_W    (CNT_W),
    .TICK_BIT (TICK_BIT)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .cnt  (cnt),
    .tick (tick)
  );

  logic [N_LED-1:0] div_led;
  for (genvar i = 0; i < N_LED; i++) begin : g_tap
    assign div_led[i] = cnt[TAP_TOP - i * TAP_STEP];
  end

  // Only the taps and the PWM slice of the counter are consumed here.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

  led_mode_e        mode_q;
  logic [N_LED-1:0] chase_q, chase_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  led_dir_e         dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             mode_chg;
  logic             step;
  logic             pwm_on;

  always_comb begin
    mode_chg = (bus.mode != mode_q);
    // A tick landing on a mode change is dropped so the new pattern starts clean.
    step     = bus.en && tick && !mode_chg;
    chase_d  = chase_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    if (mode_chg) begin
      chase_d = ChaseInit;
      duty_d  = '0;
      dir_d   = DirUp;
    end else if (step) begin
      // Shift-or rotate also degenerates correctly to a fixed bit when N_LED is 1.
      chase_d = (chase_q << 1) | (chase_q >> (N_LED - 1));
      unique case (dir_q)
        DirUp: begin
          if (duty_q == DutyMax) begin
            dir_d  = DirDown;
            duty_d = duty_q - PWM_W'(1);
          end else begin
            duty_d = duty_q + PWM_W'(1);
          end
        end
        DirDown: begin
          if (duty_q == '0) begin
            dir_d  = DirUp;
            duty_d = duty_q + PWM_W'(1);
          end else begin
            duty_d = duty_q - PWM_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    pwm_on = (cnt[PWM_W-1:0] < duty_d);
    led_d  = led_q;
    if (bus.en) begin
      unique case (bus.mode)
        DIV:     led_d = div_led;
        CHASE:   led_d = chase_d;
        BREATHE: led_d = {N_LED{pwm_on}};
        OFF:     led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= DIV;
      chase_q <= ChaseInit;
      duty_q  <= '0;
      dir_q   <= DirUp;
      led_q   <= '0;
    end else begin
      mode_q  <= bus.mode;
      chase_q <= chase_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen in a shrunk configuration (8-bit counter,
// tick every 4 cycles, 2-bit duty).
module tb_led_pattern_gen;
  import led_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  led_pattern_gen_if #(.N_LED(4)) bus ();

  led_pattern_gen #(
    .N_LED    (4),
    .CNT_W    (8),
    .TAP_TOP  (7),
    .TAP_STEP (2),
    .TICK_BIT (1),
    .PWM_W    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves inputs set so the next cyc() is the first edge after release.
  task automatic do_reset(input led_mode_e m);
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = DIV;
    cyc();
    cyc();
    rst      = 1'b0;
    bus.en   = 1'b1;
    bus.mode = m;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.mode = CHASE;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if (bus.led !== 4'b0000) begin
        n_err++; $display("FAIL reset_led: got %b want 0000", bus.led);
      end
      n_cmp++;
      if (bus.tick !== 1'b0) begin
        n_err++; $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      n_cmp++;
      if (dut.u_tick_gen.cnt_q !== 8'd0) begin
        n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.u_tick_gen.cnt_q);
      end
      n_cmp++;
      if (dut.duty_q !== 2'd0) begin
        n_err++; $display("FAIL reset_duty: got %0d want 0", dut.duty_q);
      end
    end
  endtask

  task automatic test_div();
    logic [7:0] c;
    logic [3:0] exp_led;
    do_reset(DIV);
    for (int k = 1; k <= 260; k++) begin
      cyc();
      c       = 8'((k - 1) & 255);
      exp_led = {c[1], c[3], c[5], c[7]};
      n_cmp++;
      if (dut.u_tick_gen.cnt_q !== 8'(k & 255)) begin
        n_err++; $display("FAIL div_cnt k=%0d: got %0d want %0d", k, dut.u_tick_gen.cnt_q, k & 255);
      end
      n_cmp++;
      if (bus.led !== exp_led) begin
        n_err++; $display("FAIL div_led k=%0d: got %b want %b", k, bus.led, exp_led);
      end
      n_cmp++;
      if (bus.tick !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL div_tick k=%0d: got %b want %b", k, bus.tick, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_led;
    do_reset(CHASE);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      exp_led = 4'b0001 << (((k - 1) / 4) % 4);
      n_cmp++;
      if (bus.led !== exp_led) begin
        n_err++; $display("FAIL chase_led k=%0d: got %b want %b", k, bus.led, exp_led);
      end
      n_cmp++;
      if (bus.tick !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL chase_tick k=%0d: got %b want %b", k, bus.tick, (k % 4) == 0);
      end
    end
  endtask

  task automatic test_breathe();
    int         seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int         d;
    logic [3:0] exp_led;
    do_reset(BREATHE);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      d       = seq[(k - 1) / 4];
      exp_led = (((k - 1) % 4) < d) ? 4'hF : 4'h0;
      n_cmp++;
      if (dut.duty_q !== 2'(d)) begin
        n_err++; $display("FAIL breathe_duty k=%0d: got %0d want %0d", k, dut.duty_q, d);
      end
      n_cmp++;
      if (bus.led !== exp_led) begin
        n_err++; $display("FAIL breathe_led k=%0d: got %b want %b", k, bus.led, exp_led);
      end
    end
  endtask

  task automatic test_off();
    do_reset(OFF);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      n_cmp++;
      if (bus.led !== 4'b0000) begin
        n_err++; $display("FAIL off_led k=%0d: got %b want 0000", k, bus.led);
      end
      n_cmp++;
      if (bus.tick !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL off_tick k=%0d: got %b want %b", k, bus.tick, (k % 4) == 0);
      end
      n_cmp++;
      if (dut.u_tick_gen.cnt_q !== 8'(k)) begin
        n_err++; $display("FAIL off_cnt k=%0d: got %0d want %0d", k, dut.u_tick_gen.cnt_q, k);
      end
    end
  endtask

  task automatic test_en_hold();
    logic [3:0] exp_led;
    do_reset(CHASE);
    for (int k = 1; k <= 10; k++) cyc();
    n_cmp++;
    if (bus.led !== 4'b0100) begin
      n_err++; $display("FAIL hold_pre_led: got %b want 0100", bus.led);
    end
    bus.en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      n_cmp++;
      if (bus.led !== 4'b0100) begin
        n_err++; $display("FAIL hold_led j=%0d: got %b want 0100", j, bus.led);
      end
      n_cmp++;
      if (bus.tick !== 1'b0) begin
        n_err++; $display("FAIL hold_tick j=%0d: got %b want 0", j, bus.tick);
      end
      n_cmp++;
      if (dut.u_tick_gen.cnt_q !== 8'd10) begin
        n_err++; $display("FAIL hold_cnt j=%0d: got %0d want 10", j, dut.u_tick_gen.cnt_q);
      end
    end
    bus.en = 1'b1;
    for (int kk = 11; kk <= 22; kk++) begin
      cyc();
      exp_led = 4'b0001 << (((kk - 1) / 4) % 4);
      n_cmp++;
      if (bus.led !== exp_led) begin
        n_err++; $display("FAIL resume_led kk=%0d: got %b want %b", kk, bus.led, exp_led);
      end
      n_cmp++;
      if (bus.tick !== ((kk % 4) == 0)) begin
        n_err++; $display("FAIL resume_tick kk=%0d: got %b want %b", kk, bus.tick, (kk % 4) == 0);
      end
    end
  endtask

  task automatic test_mode_switch();
    do_reset(CHASE);
    for (int k = 1; k <= 4; k++) cyc();
    n_cmp++;
    if (bus.tick !== 1'b1) begin
      n_err++; $display("FAIL sw_tick_before: got %b want 1", bus.tick);
    end
    bus.mode = BREATHE;
    cyc();
    n_cmp++;
    if (dut.duty_q !== 2'd0) begin
      n_err++; $display("FAIL sw_duty_discard: got %0d want 0", dut.duty_q);
    end
    n_cmp++;
    if (bus.led !== 4'b0000) begin
      n_err++; $display("FAIL sw_breathe_led: got %b want 0000", bus.led);
    end
    cyc();
    n_cmp++;
    if (dut.duty_q !== 2'd0 || bus.led !== 4'b0000) begin
      n_err++; $display("FAIL sw_breathe_hold: got duty %0d led %b want 0 0000", dut.duty_q, bus.led);
    end
    bus.mode = CHASE;
    cyc();
    n_cmp++;
    if (bus.led !== 4'b0001) begin
      n_err++; $display("FAIL sw_chase_reload: got %b want 0001", bus.led);
    end
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b1 || bus.led !== 4'b0001) begin
      n_err++; $display("FAIL sw_chase_tick: got tick %b led %b want 1 0001", bus.tick, bus.led);
    end
    cyc();
    n_cmp++;
    if (bus.led !== 4'b0010) begin
      n_err++; $display("FAIL sw_chase_step: got %b want 0010", bus.led);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(CHASE);
    for (int k = 1; k <= 9; k++) cyc();
    n_cmp++;
    if (bus.led !== 4'b0100) begin
      n_err++; $display("FAIL mid_pre_led: got %b want 0100", bus.led);
    end
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (bus.led !== 4'b0000 || bus.tick !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got led %b tick %b want 0000 0", bus.led, bus.tick);
    end
    n_cmp++;
    if (dut.u_tick_gen.cnt_q !== 8'd0) begin
      n_err++; $display("FAIL mid_reset_cnt: got %0d want 0", dut.u_tick_gen.cnt_q);
    end
    rst = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      cyc();
      n_cmp++;
      if (bus.led !== 4'b0001 || bus.tick !== 1'b0) begin
        n_err++; $display("FAIL mid_restart f=%0d: got led %b tick %b want 0001 0", f, bus.led, bus.tick);
      end
    end
    cyc();
    n_cmp++;
    if (bus.tick !== 1'b1) begin
      n_err++; $display("FAIL mid_first_tick: got %b want 1", bus.tick);
    end
    cyc();
    n_cmp++;
    if (bus.led !== 4'b0010) begin
      n_err++; $display("FAIL mid_first_step: got %b want 0010", bus.led);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = DIV;
    test_reset();
    test_div();
    test_chase();
    test_breathe();
    test_off();
    test_en_hold();
    test_mode_switch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
